conv_result_collector: RTL

- Receiving end of the serial result stream produced by the accumulate/emit stage (result word, 4-bit valid bundle, conv-done flag).
- Reassembles each S2P_SIZE x S2P_SIZE result tile into output feature-map addresses and drops all padding entries.
- Writes surviving results to the output buffer through a single-port write interface.
- Tile order is t-tiles (output pixels) as the inner loop and w-tiles (kernels) as the outer loop.

---
 rtl/conv_result_collector.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/conv_result_collector.sv
// Reassembles streamed result tiles into output-buffer writes, dropping pixel and kernel padding.
// Optional COLLECTOR_RELU_EN clamps negative results to zero on the write path.
`default_nettype none

module conv_result_collector #(
  parameter int S2P_SIZE    = 4,
  parameter int RESULT_SIZE = 32,
  parameter int PIX_W       = 12,
  parameter int KN_W        = 8,
  parameter int ADDR_W      = 20
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [PIX_W-1:0]       cfg_out_pixels,
  input  logic [KN_W-1:0]        cfg_kernel_nums,
  input  logic [RESULT_SIZE-1:0] i_result,
  input  logic [3:0]             i_result_valid,
  input  logic                   i_conv_done,
  output logic                   o_wr_en,
  output logic [ADDR_W-1:0]      o_wr_addr,
  output logic [RESULT_SIZE-1:0] o_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int CW = (S2P_SIZE > 1) ? $clog2(S2P_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TILE, RECV, DONE} state_t;

  state_t                 state, state_n;
  logic [PIX_W-1:0]       pix_cfg, pix_cfg_n;
  logic [KN_W-1:0]        kn_cfg, kn_cfg_n;
  logic [CW-1:0]          row, row_n, col, col_n;
  logic [PIX_W-1:0]       t_tile, t_tile_n;
  logic [KN_W-1:0]        w_tile, w_tile_n;
  logic                   err, err_n;
  logic                   wr_en_n;
  logic [ADDR_W-1:0]      wr_addr_n;
  logic [RESULT_SIZE-1:0] wr_data_n;

  logic                   take_beat;
  logic [CW-1:0]          beat_row, beat_col;
  logic [PIX_W-1:0]       last_t;
  logic [ADDR_W-1:0]      pixel, kernel;
  logic                   in_range;
  logic [RESULT_SIZE-1:0] data_out;

  wire v_pad   = i_result_valid[0];
  wire v_beat  = i_result_valid[1];
  wire v_start = i_result_valid[2];
  wire v_last  = i_result_valid[3];

  assign last_t   = (pix_cfg - PIX_W'(1)) / PIX_W'(S2P_SIZE);
  assign pixel    = ADDR_W'(t_tile) * ADDR_W'(S2P_SIZE) + ADDR_W'(beat_row);
  assign kernel   = ADDR_W'(w_tile) * ADDR_W'(S2P_SIZE) + ADDR_W'(beat_col);
  assign in_range = (pixel < ADDR_W'(pix_cfg)) && (kernel < ADDR_W'(kn_cfg));

`ifdef COLLECTOR_RELU_EN
  assign data_out = i_result[RESULT_SIZE-1] ? '0 : i_result;
`else
  assign data_out = i_result;
`endif

  always_comb begin
    state_n   = state;
    pix_cfg_n = pix_cfg;
    kn_cfg_n  = kn_cfg;
    row_n     = row;
    col_n     = col;
    t_tile_n  = t_tile;
    w_tile_n  = w_tile;
    err_n     = err;
    wr_en_n   = 1'b0;
    wr_addr_n = o_wr_addr;
    wr_data_n = o_wr_data;
    take_beat = 1'b0;
    beat_row  = row;
    beat_col  = col;

    if (start) begin
      pix_cfg_n = cfg_out_pixels;
      kn_cfg_n  = cfg_kernel_nums;
      row_n     = '0;
      col_n     = '0;
      t_tile_n  = '0;
      w_tile_n  = '0;
      err_n     = 1'b0;
      state_n   = WAIT_TILE;
    end else begin
      case (state)
        WAIT_TILE: begin
          if (v_beat && v_start) begin
            take_beat = 1'b1;
            beat_row  = '0;
            beat_col  = '0;
            state_n   = RECV;
          end else begin
            if (v_beat) err_n = 1'b1;
            if (i_conv_done) state_n = DONE;
          end
        end
        RECV: begin
          if (!v_beat) begin
            // Partial tile is abandoned; tile counters stay so the resend lands on the same addresses.
            err_n   = 1'b1;
            row_n   = '0;
            col_n   = '0;
            state_n = WAIT_TILE;
          end else begin
            take_beat = 1'b1;
            if (v_start && (row != '0 || col != '0)) begin
              err_n    = 1'b1;
              beat_row = '0;
              beat_col = '0;
            end
          end
        end
        default: ;
      endcase
    end

    if (take_beat) begin
      wr_en_n = v_pad && in_range;
      if (v_pad && in_range) begin
        wr_addr_n = kernel * ADDR_W'(pix_cfg) + pixel;
        wr_data_n = data_out;
      end
      if (beat_row == '0 && beat_col == '0 && (v_last != (t_tile == last_t)))
        err_n = 1'b1;

      if (beat_row == CW'(S2P_SIZE - 1)) begin
        row_n = '0;
        if (beat_col == CW'(S2P_SIZE - 1)) begin
          col_n = '0;
          if (t_tile == last_t) begin
            t_tile_n = '0;
            w_tile_n = w_tile + KN_W'(1);
          end else begin
            t_tile_n = t_tile + PIX_W'(1);
          end
          state_n = i_conv_done ? DONE : WAIT_TILE;
        end else begin
          col_n = beat_col + CW'(1);
        end
      end else begin
        row_n = beat_row + CW'(1);
        col_n = beat_col;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pix_cfg   <= '0;
      kn_cfg    <= '0;
      row       <= '0;
      col       <= '0;
      t_tile    <= '0;
      w_tile    <= '0;
      err       <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      state     <= state_n;
      pix_cfg   <= pix_cfg_n;
      kn_cfg    <= kn_cfg_n;
      row       <= row_n;
      col       <= col_n;
      t_tile    <= t_tile_n;
      w_tile    <= w_tile_n;
      err       <= err_n;
      o_wr_en   <= wr_en_n;
      o_wr_addr <= wr_addr_n;
      o_wr_data <= wr_data_n;
    end
  end

  assign o_busy = (state == WAIT_TILE) || (state == RECV);
  assign o_done = (state == DONE);
  assign o_err  = err;

endmodule

`default_nettype wire
